// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle expiry pulse and optional periodic auto-reload.
// Latency: done rises N enabled edges after the load edge; all outputs except zero are registered.
// No backpressure: enable gates counting, and load overrides everything except reset.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous, active-low reset
//   enable       decrement one per clock while in RUN
//   load         single-cycle strobe that captures load_value and (re)starts the timer
//   load_value   start/reload count N (N == 0 loads and stays idle)
//   auto_reload  1 = periodic, 0 = one-shot; sampled only on the terminal cycle
//   counter_out  current count
//   busy         high while in RUN
//   done         one-cycle pulse on expiry
//   zero         combinational (counter_out == 0)
//   irq_clear    (DOWN_COUNTER_IRQ_EN only) clears the sticky irq flag
//   irq          (DOWN_COUNTER_IRQ_EN only) sticky flag set by any done pulse
//
// Build option: define DOWN_COUNTER_IRQ_EN to add the sticky interrupt flag.

module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
`ifdef DOWN_COUNTER_IRQ_EN
    input  logic             irq_clear,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_terminal;

    // Terminal cycle: the enabled edge that takes the count from 1 to expiry.
    // Anything at or below 1 in RUN is treated as terminal so the count can
    // never wrap to all-ones.
    assign w_terminal = (r_state == RUN) && enable && (r_count <= WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (load) begin
            // A load restarts the timer even on a terminal cycle; no done.
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = (load_value != '0) ? RUN : IDLE;
        end else begin
            case (r_state)
                RUN: begin
                    if (enable) begin
                        if (w_terminal) begin
                            w_done_nxt = 1'b1;
                            if (auto_reload) begin
                                w_count_nxt = r_reload;
                                w_state_nxt = RUN;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // IDLE ignores enable and holds the count.
                    w_state_nxt = IDLE;
                end
            endcase
        end

        // busy is registered and tracks the state being entered.
        w_busy_nxt = (w_state_nxt == RUN);
    end

`ifdef DOWN_COUNTER_IRQ_EN
    logic r_irq;

    // Set is taken from the same next-value that drives done, so irq rises
    // together with done; set beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else if (w_done_nxt) begin
            r_irq <= 1'b1;
        end else if (irq_clear) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign counter_out = r_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign zero        = (r_count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expected values.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// No backpressure in the DUT; every wait is one bounded clock step.

module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] counter_out;
    logic             busy;
    logic             done;
    logic             zero;
`ifdef DOWN_COUNTER_IRQ_EN
    logic             irq_clear;
    logic             irq;
`endif

    int n_vec;
    int n_miss;

    down_counter_timer #(.WIDTH(WIDTH)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
`ifdef DOWN_COUNTER_IRQ_EN
        .irq_clear   (irq_clear),
        .irq         (irq),
`endif
        .counter_out (counter_out),
        .busy        (busy),
        .done        (done),
        .zero        (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input int cnt, input int b, input int d);
        chk({tag, ".cnt"},  int'(counter_out), cnt);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".zero"}, int'(zero), (cnt == 0) ? 1 : 0);
    endtask

    task automatic do_load(input int v, input logic ar);
        load        = 1'b1;
        load_value  = WIDTH'(v);
        auto_reload = ar;
        step();
        load        = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset       = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        auto_reload = 1'b0;
`ifdef DOWN_COUNTER_IRQ_EN
        irq_clear   = 1'b0;
`endif

        // Reset state
        #3;
        chk_out("rst", 0, 0, 0);
`ifdef DOWN_COUNTER_IRQ_EN
        chk("rst.irq", int'(irq), 0);
`endif
        @(negedge clock);
        reset = 1'b1;

        // Reset mid-count: load 9, three enabled edges, then async reset
        enable = 1'b1;
        do_load(9, 1'b0);
        chk_out("mid.load", 9, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("mid.c%0d", i), 9 - i, 1, 0);
        end
        #2;
        reset = 1'b0;
        #1;
        chk_out("mid.async", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk_out("mid.after", 0, 0, 0);

        // One-shot N=5: 5,4,3,2,1,0 with done coincident with 0
        enable = 1'b1;
        do_load(5, 1'b0);
        chk_out("os.load", 5, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_out($sformatf("os.c%0d", i), 5 - i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
        end
        step();
        chk_out("os.hold1", 0, 0, 0);
        step();
        chk_out("os.hold2", 0, 0, 0);

        // Enable gaps: N=3, enable pattern 1,0,0,1,1
        begin
            logic [4:0] en_pat;
            int         exp_cnt [5];
            en_pat  = 5'b11001;   // bit 0 applied first
            exp_cnt = '{2, 2, 2, 1, 0};
            do_load(3, 1'b0);
            chk_out("gap.load", 3, 1, 0);
            for (int i = 0; i < 5; i++) begin
                enable = en_pat[i];
                step();
                chk_out($sformatf("gap.c%0d", i), exp_cnt[i], (i < 4) ? 1 : 0, (i == 4) ? 1 : 0);
            end
        end

        // Periodic N=4 for 12 enabled cycles
        enable = 1'b1;
        do_load(4, 1'b1);
        chk_out("per.load", 4, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_out($sformatf("per.c%0d", k), 4 - (k % 4), 1, (k % 4 == 0) ? 1 : 0);
        end

        // auto_reload dropped mid-count: next terminal cycle is one-shot
        auto_reload = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_out($sformatf("per2os.c%0d", k), (k < 4) ? 4 - k : 0, (k < 4) ? 1 : 0, (k == 4) ? 1 : 0);
        end

        // Periodic N=1: done every enabled cycle
        do_load(1, 1'b1);
        chk_out("n1.load", 1, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_out($sformatf("n1.c%0d", k), 1, 1, 1);
        end

        // Load 0: idle, enable ignored, no wrap
        do_load(0, 1'b0);
        chk_out("z.load", 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_out($sformatf("z.c%0d", k), 0, 0, 0);
        end

        // Load max 15: done after 15 enabled cycles
        do_load(15, 1'b0);
        chk_out("max.load", 15, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_out($sformatf("max.c%0d", k), 15 - k, (k < 15) ? 1 : 0, (k == 15) ? 1 : 0);
        end

        // Load on the terminal cycle wins
        do_load(2, 1'b0);
        step();
        chk_out("lt.pre", 1, 1, 0);
        load       = 1'b1;
        load_value = WIDTH'(7);
        step();
        load       = 1'b0;
        chk_out("lt.load", 7, 1, 0);
        step();
        chk_out("lt.next", 6, 1, 0);

`ifdef DOWN_COUNTER_IRQ_EN
        // IRQ: one-shot N=2, irq rises with done and holds
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("irq.rst", int'(irq), 0);
        enable = 1'b1;
        do_load(2, 1'b0);
        chk("irq.load", int'(irq), 0);
        step();
        chk("irq.c1", int'(irq), 0);
        step();
        chk_out("irq.done", 0, 0, 1);
        chk("irq.set", int'(irq), 1);
        step();
        chk("irq.hold", int'(irq), 1);
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        chk("irq.clr", int'(irq), 0);

        // Clear on the edge that produces done: set wins
        do_load(1, 1'b0);
        irq_clear = 1'b1;
        step();
        irq_clear = 1'b0;
        chk("irq.sd.done", int'(done), 1);
        chk("irq.sd.irq", int'(irq), 1);
        step();
        chk("irq.sd.hold", int'(irq), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
